// File: rtl/mul_final_add.sv
// rtl/mul_final_add.sv - final carry-propagate add, result FIFO and issue credits for the Booth/Wallace multiplier
// Optional input register stage before the adder: MUL_FINAL_ADD_REG_EN (issue-to-result latency 3 instead of 2).
module mul_final_add #(
  parameter int RES_W = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue_valid,
  output logic             issue_allow,
  input  logic [RES_W-1:0] cs_a,
  input  logic [RES_W-1:0] cs_b,
  input  logic             cs_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic             ovf_err
);

`ifdef MUL_FINAL_ADD_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [LAT-1:0]   trk;
  logic [CW-1:0]    fifo_count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [RES_W-1:0] mem [DEPTH];
  logic [CW:0]      inflight_count;
  logic             issue_ok;
  logic             capture;
  logic             pop;
  logic [RES_W-1:0] add_a;
  logic [RES_W-1:0] add_b;
  logic             add_cin;
  logic [RES_W-1:0] sum;
  logic             unused_msb;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign issue_ok = issue_valid && issue_allow;
  assign capture  = trk[LAT-2];
  assign pop      = res_valid && res_ready;

  // Stages up to and including the capture stage hold a reserved slot; after
  // capture the product is already counted in fifo_count.
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < LAT - 1; i++) begin
      inflight_count = inflight_count + (CW + 1)'(trk[i]);
    end
  end

  assign issue_allow = ((CW + 1)'(fifo_count) + inflight_count) < (CW + 1)'(DEPTH);

`ifdef MUL_FINAL_ADD_REG_EN
  logic [RES_W-1:0] a_q;
  logic [RES_W-1:0] b_q;
  logic             cin_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else if (trk[0]) begin
      a_q   <= cs_a;
      b_q   <= cs_b;
      cin_q <= cs_cin;
    end
  end

  assign add_a   = a_q;
  assign add_b   = b_q;
  assign add_cin = cin_q;
  assign unused_msb = a_q[RES_W-1];
`else
  assign add_a   = cs_a;
  assign add_b   = cs_b;
  assign add_cin = cs_cin;
  assign unused_msb = cs_a[RES_W-1];
`endif

  // The carry of column i feeds column i+1; the top carry falls off the product.
  assign sum = add_b + {add_a[RES_W-2:0], add_cin};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      trk        <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf_err    <= 1'b0;
    end else begin
      trk <= {trk[LAT-2:0], issue_ok};
      if (issue_valid && !issue_allow) begin
        ovf_err <= 1'b1;
      end
      if (capture) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && capture) begin
      mem[wr_ptr] <= sum;
    end
  end

  assign res_valid = (fifo_count != '0);
  assign result    = res_valid ? mem[rd_ptr] : '0;
  assign busy      = (|trk) || res_valid;

endmodule
